// File: rtl/ram_seq_ctrl.sv
// Command sequencer driving a single-port 64-word RAM: fill, dwell scan, single write, single read.
// All RAM-side outputs are registered; a command completes with a one-cycle done pulse unless aborted.
module ram_seq_ctrl #(
    parameter int unsigned DWELL = 4,
    parameter logic [31:0] SEED  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic        abort,
    input  logic [5:0]  addr_in,
    input  logic [31:0] data_in,
    output logic [5:0]  Mem_Addr,
    output logic        Mem_Write,
    output logic        Mem_Read,
    output logic [31:0] M_W_Data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SCAN,
        S_SWR,
        S_SRD,
        S_DONE
    } state_t;

    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
    localparam logic [5:0]  LAST_ADDR = 6'd63;

    state_t      state, state_nxt;
    logic [5:0]  addr_nxt;
    logic        wr_nxt, rd_nxt, busy_nxt, done_nxt;
    logic [31:0] data_nxt;
    logic [15:0] dwell_cnt, dwell_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            Mem_Addr  <= '0;
            Mem_Write <= 1'b0;
            Mem_Read  <= 1'b0;
            M_W_Data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nxt;
            Mem_Addr  <= addr_nxt;
            Mem_Write <= wr_nxt;
            Mem_Read  <= rd_nxt;
            M_W_Data  <= data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            dwell_cnt <= dwell_nxt;
        end
    end

    // Next-cycle values of every registered output; strobes default low so
    // any path that does not explicitly continue a command drops them.
    always_comb begin
        state_nxt = state;
        addr_nxt  = Mem_Addr;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        data_nxt  = M_W_Data;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        dwell_nxt = dwell_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_nxt = 1'b1;
                    case (cmd)
                        2'b00: begin
                            state_nxt = S_FILL;
                            addr_nxt  = '0;
                            wr_nxt    = 1'b1;
                            data_nxt  = SEED;
                        end
                        2'b01: begin
                            state_nxt = S_SCAN;
                            addr_nxt  = '0;
                            rd_nxt    = 1'b1;
                            dwell_nxt = DWELL_M1;
                        end
                        2'b10: begin
                            state_nxt = S_SWR;
                            addr_nxt  = addr_in;
                            wr_nxt    = 1'b1;
                            data_nxt  = data_in;
                        end
                        default: begin
                            state_nxt = S_SRD;
                            addr_nxt  = addr_in;
                            rd_nxt    = 1'b1;
                            dwell_nxt = DWELL_M1;
                        end
                    endcase
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (Mem_Addr == LAST_ADDR) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt = Mem_Addr + 6'd1;
                    wr_nxt   = 1'b1;
                    data_nxt = SEED + {26'd0, addr_nxt};
                    busy_nxt = 1'b1;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (dwell_cnt == 16'd0 && Mem_Addr == LAST_ADDR) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    rd_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                    if (dwell_cnt == 16'd0) begin
                        addr_nxt  = Mem_Addr + 6'd1;
                        dwell_nxt = DWELL_M1;
                    end else begin
                        dwell_nxt = dwell_cnt - 16'd1;
                    end
                end
            end
            S_SWR: begin
                state_nxt = S_IDLE;
                if (!abort) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            S_SRD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (dwell_cnt == 16'd0) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    rd_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    dwell_nxt = dwell_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
